// File: rtl/mem_wb_pipe_if.sv
// mem_wb_pipe_if: MEM/WB stage bus bundle.
//   master modport : MEM-side driver / WB-side consumer (flush, input entry, out_ready,
//                    observes the head entry and handshake outputs)
//   slave modport  : the mem_wb_pipe stage itself
//   Signals: flush, in_valid/in_ready, control_wb_in, read_data_in, alu_result_in,
//            write_reg_in, out_valid/out_ready, regwrite, memtoreg, ctrl_out, read_data,
//            mem_alu_result, mem_write_reg, wb_data, occupancy.
//   Optional (MEM_WB_FWD_EN): fwd_rs1/fwd_rs2 in, fwd_hit_rs1/fwd_hit_rs2 out.
interface mem_wb_pipe_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 2
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] control_wb_in;
  logic [DATA_W-1:0] read_data_in;
  logic [DATA_W-1:0] alu_result_in;
  logic [REG_AW-1:0] write_reg_in;
  logic              out_valid;
  logic              out_ready;
  logic              regwrite;
  logic              memtoreg;
  logic [CTRL_W-1:0] ctrl_out;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] mem_alu_result;
  logic [REG_AW-1:0] mem_write_reg;
  logic [DATA_W-1:0] wb_data;
  logic [1:0]        occupancy;
`ifdef MEM_WB_FWD_EN
  logic [REG_AW-1:0] fwd_rs1;
  logic [REG_AW-1:0] fwd_rs2;
  logic              fwd_hit_rs1;
  logic              fwd_hit_rs2;

  modport master (
    output flush, in_valid, control_wb_in, read_data_in, alu_result_in, write_reg_in,
           out_ready, fwd_rs1, fwd_rs2,
    input  in_ready, out_valid, regwrite, memtoreg, ctrl_out, read_data, mem_alu_result,
           mem_write_reg, wb_data, occupancy, fwd_hit_rs1, fwd_hit_rs2
  );
  modport slave (
    input  flush, in_valid, control_wb_in, read_data_in, alu_result_in, write_reg_in,
           out_ready, fwd_rs1, fwd_rs2,
    output in_ready, out_valid, regwrite, memtoreg, ctrl_out, read_data, mem_alu_result,
           mem_write_reg, wb_data, occupancy, fwd_hit_rs1, fwd_hit_rs2
  );
`else
  modport master (
    output flush, in_valid, control_wb_in, read_data_in, alu_result_in, write_reg_in,
           out_ready,
    input  in_ready, out_valid, regwrite, memtoreg, ctrl_out, read_data, mem_alu_result,
           mem_write_reg, wb_data, occupancy
  );
  modport slave (
    input  flush, in_valid, control_wb_in, read_data_in, alu_result_in, write_reg_in,
           out_ready,
    output in_ready, out_valid, regwrite, memtoreg, ctrl_out, read_data, mem_alu_result,
           mem_write_reg, wb_data, occupancy
  );
`endif
endinterface

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM/WB pipeline register with valid/ready handshake and a 2-entry
// (head + skid) buffer. The head entry drives the WB stage and register file.
//   clk   : core clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : mem_wb_pipe_if.slave (flush, input entry, handshake, head outputs, occupancy)
// Optional feature macro MEM_WB_FWD_EN: forwarding compare of the head destination
// against fwd_rs1/fwd_rs2 (wb_data is the forwarding value).
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 2
) (
  input  logic          clk,
  input  logic          reset,
  mem_wb_pipe_if.slave  bus
);

  logic              head_valid_q, head_valid_d;
  logic [CTRL_W-1:0] head_ctrl_q,  head_ctrl_d;
  logic [DATA_W-1:0] head_rd_q,    head_rd_d;
  logic [DATA_W-1:0] head_alu_q,   head_alu_d;
  logic [REG_AW-1:0] head_wr_q,    head_wr_d;

  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_rd_q,    skid_rd_d;
  logic [DATA_W-1:0] skid_alu_q,   skid_alu_d;
  logic [REG_AW-1:0] skid_wr_q,    skid_wr_d;

  logic accept;
  logic release_head;

  // in_ready depends only on registered state, so out_ready never reaches it.
  assign accept       = bus.in_valid & ~skid_valid_q;
  assign release_head = head_valid_q & bus.out_ready;

  always_comb begin
    head_valid_d = head_valid_q;
    head_ctrl_d  = head_ctrl_q;
    head_rd_d    = head_rd_q;
    head_alu_d   = head_alu_q;
    head_wr_d    = head_wr_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_rd_d    = skid_rd_q;
    skid_alu_d   = skid_alu_q;
    skid_wr_d    = skid_wr_q;

    if (bus.flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!head_valid_q) begin
      // Skid is never occupied while the head is empty.
      if (accept) begin
        head_valid_d = 1'b1;
        head_ctrl_d  = bus.control_wb_in;
        head_rd_d    = bus.read_data_in;
        head_alu_d   = bus.alu_result_in;
        head_wr_d    = bus.write_reg_in;
      end
    end else if (release_head) begin
      if (skid_valid_q) begin
        head_ctrl_d  = skid_ctrl_q;
        head_rd_d    = skid_rd_q;
        head_alu_d   = skid_alu_q;
        head_wr_d    = skid_wr_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        head_ctrl_d  = bus.control_wb_in;
        head_rd_d    = bus.read_data_in;
        head_alu_d   = bus.alu_result_in;
        head_wr_d    = bus.write_reg_in;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = bus.control_wb_in;
      skid_rd_d    = bus.read_data_in;
      skid_alu_d   = bus.alu_result_in;
      skid_wr_d    = bus.write_reg_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_valid_q <= 1'b0;
      head_ctrl_q  <= '0;
      head_rd_q    <= '0;
      head_alu_q   <= '0;
      head_wr_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_rd_q    <= '0;
      skid_alu_q   <= '0;
      skid_wr_q    <= '0;
    end else begin
      head_valid_q <= head_valid_d;
      head_ctrl_q  <= head_ctrl_d;
      head_rd_q    <= head_rd_d;
      head_alu_q   <= head_alu_d;
      head_wr_q    <= head_wr_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_rd_q    <= skid_rd_d;
      skid_alu_q   <= skid_alu_d;
      skid_wr_q    <= skid_wr_d;
    end
  end

  assign bus.in_ready       = ~skid_valid_q;
  assign bus.out_valid      = head_valid_q;
  assign bus.ctrl_out       = head_ctrl_q;
  assign bus.read_data      = head_rd_q;
  assign bus.mem_alu_result = head_alu_q;
  assign bus.mem_write_reg  = head_wr_q;
  // x0 is hardwired zero; never issue a write to it.
  assign bus.regwrite       = head_valid_q & head_ctrl_q[1] & (head_wr_q != '0);
  assign bus.memtoreg       = head_ctrl_q[0];
  assign bus.wb_data        = head_ctrl_q[0] ? head_rd_q : head_alu_q;
  assign bus.occupancy      = {1'b0, head_valid_q} + {1'b0, skid_valid_q};

`ifdef MEM_WB_FWD_EN
  assign bus.fwd_hit_rs1 = bus.regwrite & (head_wr_q == bus.fwd_rs1);
  assign bus.fwd_hit_rs2 = bus.regwrite & (head_wr_q == bus.fwd_rs2);
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
module tb_mem_wb_pipe;

  typedef struct packed {
    logic [1:0]  ctrl;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_wb_pipe_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(2)) bus ();

  mem_wb_pipe #(.DATA_W(32), .REG_AW(5), .CTRL_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int   n_chk  = 0;
  int   n_pass = 0;
  ent_t sb[$];
  bit   last_acc;

  task automatic drive(input ent_t e);
    bus.in_valid      = 1'b1;
    bus.control_wb_in = e.ctrl;
    bus.read_data_in  = e.rd;
    bus.alu_result_in = e.alu;
    bus.write_reg_in  = e.wr;
  endtask

  function automatic ent_t mk(input logic [1:0] c, input logic [31:0] r,
                              input logic [31:0] a, input logic [4:0] w);
    ent_t e;
    e.ctrl = c; e.rd = r; e.alu = a; e.wr = w;
    return e;
  endfunction

  // One clock: model handshake from scoreboard state, advance, return at negedge.
  task automatic tick();
    bit   acc, rel;
    ent_t cur;
    cur = mk(bus.control_wb_in, bus.read_data_in, bus.alu_result_in, bus.write_reg_in);
    acc = bus.in_valid && (sb.size() < 2);
    rel = (sb.size() > 0) && bus.out_ready;
    @(posedge clk);
    if (bus.flush) sb.delete();
    else begin
      if (rel) sb.delete(0);
      if (acc) sb.push_back(cur);
    end
    last_acc = acc && !bus.flush;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); else n_pass++;
    n_chk++; if (bus.occupancy !== 2'd0) $display("FAIL rst_occ got %0d exp 0", bus.occupancy); else n_pass++;
    drive(mk(2'b10, 32'h55, 32'h77, 5'd3));
    tick();
    bus.in_valid = 1'b0;
    n_chk++; if (bus.out_valid !== 1'b1) $display("FAIL rst_pre_valid got %b exp 1", bus.out_valid); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL rst_async_valid got %b exp 0", bus.out_valid); else n_pass++;
    n_chk++; if (bus.regwrite !== 1'b0) $display("FAIL rst_async_regwrite got %b exp 0", bus.regwrite); else n_pass++;
    n_chk++; if (bus.memtoreg !== 1'b0) $display("FAIL rst_async_memtoreg got %b exp 0", bus.memtoreg); else n_pass++;
    n_chk++; if (bus.occupancy !== 2'd0) $display("FAIL rst_async_occ got %0d exp 0", bus.occupancy); else n_pass++;
    n_chk++; if (bus.mem_alu_result !== 32'h0) $display("FAIL rst_async_alu got %h exp 0", bus.mem_alu_result); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    #1;
    n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL rst_rel_in_ready got %b exp 1", bus.in_ready); else n_pass++;
    n_chk++; if (bus.occupancy !== 2'd0) $display("FAIL rst_rel_occ got %0d exp 0", bus.occupancy); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_stream();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(mk(2'b10, $urandom, 32'h10 + 32'(i), 5'd5));
      tick();
      n_chk++;
      if (bus.out_valid !== 1'b1 || sb.size() == 0)
        $display("FAIL stream_valid[%0d] got %b exp 1", i, bus.out_valid);
      else if (bus.mem_alu_result !== sb[0].alu)
        $display("FAIL stream_alu[%0d] got %h exp %h", i, bus.mem_alu_result, sb[0].alu);
      else n_pass++;
      n_chk++; if (bus.regwrite !== 1'b1) $display("FAIL stream_regwrite[%0d] got %b exp 1", i, bus.regwrite); else n_pass++;
      n_chk++; if (bus.occupancy !== 2'd1) $display("FAIL stream_occ[%0d] got %0d exp 1", i, bus.occupancy); else n_pass++;
    end
    bus.in_valid = 1'b0;
    tick();
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL stream_empty got %b exp 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_back_pressure();
    ent_t        e[3];
    logic [31:0] drained[$];
    bit          sent;
    for (int k = 0; k < 3; k++) e[k] = mk(2'b10, 32'h0, 32'hA0 + 32'(k), 5'(k + 1));
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin drive(e[k]); tick(); end
    n_chk++; if (bus.occupancy !== 2'd2) $display("FAIL bp_occ got %0d exp 2", bus.occupancy); else n_pass++;
    n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready got %b exp 0", bus.in_ready); else n_pass++;
    // Bus changes while stalled must not disturb held entries.
    bus.alu_result_in = 32'hBAD0BAD0;
    tick();
    drive(e[2]);
    n_chk++; if (bus.mem_alu_result !== 32'hA0) $display("FAIL bp_head got %h exp a0", bus.mem_alu_result); else n_pass++;
    bus.out_ready = 1'b1;
    sent = 1'b0;
    for (int c = 0; c < 10 && (sb.size() > 0 || !sent); c++) begin
      if (bus.out_valid === 1'b1) drained.push_back(bus.mem_alu_result);
      tick();
      if (last_acc) begin sent = 1'b1; bus.in_valid = 1'b0; end
    end
    n_chk++;
    if (drained.size() != 3) $display("FAIL bp_drain_count got %0d exp 3", drained.size());
    else n_pass++;
    for (int k = 0; k < 3 && k < drained.size(); k++) begin
      n_chk++;
      if (drained[k] !== 32'hA0 + 32'(k)) $display("FAIL bp_order[%0d] got %h exp %h", k, drained[k], 32'hA0 + 32'(k));
      else n_pass++;
    end
    n_chk++; if (bus.occupancy !== 2'd0) $display("FAIL bp_final_occ got %0d exp 0", bus.occupancy); else n_pass++;
  endtask

  task automatic test_wb_mux();
    bus.out_ready = 1'b1;
    drive(mk(2'b11, 32'hDEADBEEF, 32'h1234, 5'd9));
    tick();
    n_chk++; if (bus.wb_data !== 32'hDEADBEEF) $display("FAIL mux_load got %h exp deadbeef", bus.wb_data); else n_pass++;
    n_chk++; if (bus.memtoreg !== 1'b1) $display("FAIL mux_memtoreg1 got %b exp 1", bus.memtoreg); else n_pass++;
    drive(mk(2'b10, 32'hDEADBEEF, 32'h1234, 5'd9));
    tick();
    n_chk++; if (bus.wb_data !== 32'h1234) $display("FAIL mux_alu got %h exp 1234", bus.wb_data); else n_pass++;
    n_chk++; if (bus.memtoreg !== 1'b0) $display("FAIL mux_memtoreg0 got %b exp 0", bus.memtoreg); else n_pass++;
    drive(mk(2'b10, 32'h0, 32'h42, 5'd0));
    tick();
    bus.in_valid = 1'b0;
    n_chk++; if (bus.out_valid !== 1'b1) $display("FAIL x0_valid got %b exp 1", bus.out_valid); else n_pass++;
    n_chk++; if (bus.regwrite !== 1'b0) $display("FAIL x0_regwrite got %b exp 0", bus.regwrite); else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(mk(2'b10, 32'h1, 32'hC0, 5'd4)); tick();
    drive(mk(2'b10, 32'h2, 32'hC1, 5'd6)); tick();
    n_chk++; if (bus.occupancy !== 2'd2) $display("FAIL fl_pre_occ got %0d exp 2", bus.occupancy); else n_pass++;
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    drive(mk(2'b10, 32'h3, 32'hC2, 5'd8));
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    n_chk++; if (bus.occupancy !== 2'd0) $display("FAIL fl_occ got %0d exp 0", bus.occupancy); else n_pass++;
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL fl_valid got %b exp 0", bus.out_valid); else n_pass++;
    n_chk++; if (bus.regwrite !== 1'b0) $display("FAIL fl_regwrite got %b exp 0", bus.regwrite); else n_pass++;
    tick();
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL fl_discard got %b exp 0", bus.out_valid); else n_pass++;
`ifdef MEM_WB_FWD_EN
    bus.fwd_rs1 = 5'd7;
    bus.fwd_rs2 = 5'd8;
    drive(mk(2'b10, 32'h0, 32'h99, 5'd7));
    tick();
    bus.in_valid = 1'b0;
    n_chk++; if (bus.fwd_hit_rs1 !== 1'b1) $display("FAIL fwd_rs1 got %b exp 1", bus.fwd_hit_rs1); else n_pass++;
    n_chk++; if (bus.fwd_hit_rs2 !== 1'b0) $display("FAIL fwd_rs2 got %b exp 0", bus.fwd_hit_rs2); else n_pass++;
    tick();
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks_passed=%0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    bus.flush         = 1'b0;
    bus.in_valid      = 1'b0;
    bus.out_ready     = 1'b0;
    bus.control_wb_in = '0;
    bus.read_data_in  = '0;
    bus.alu_result_in = '0;
    bus.write_reg_in  = '0;
`ifdef MEM_WB_FWD_EN
    bus.fwd_rs1 = '0;
    bus.fwd_rs2 = '0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    test_reset();
    test_stream();
    test_back_pressure();
    test_wb_mux();
    test_flush();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
Parametrised MEM/WB pipeline stage for the RISC-V core: a clocked register with a valid/ready handshake and a 2-entry skid buffer, replacing the old combinational delay-style latch. It captures WB control, load data, ALU result and destination register from MEM, and presents them to the WB stage and the register file. It also supports flush, x0 write suppression and an occupancy indication.

Parameters:
DATA_W, 32, width of read_data and alu_result paths
REG_AW, 5, destination register address width
CTRL_W, 2, WB control bus width; bit 1 = regwrite, bit 0 = memtoreg, any higher bits passed through untouched

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous squash of all held entries
in_valid  input  1  MEM stage presents an entry
in_ready  output  1  stage can accept an entry this cycle
control_wb_in  input  CTRL_W  WB control from MEM
read_data_in  input  DATA_W  load data
alu_result_in  input  DATA_W  ALU result
write_reg_in  input  REG_AW  destination register
out_valid  output  1  entry presented to WB
out_ready  input  1  WB accepts the entry
regwrite  output  1  qualified register-file write enable
memtoreg  output  1  WB source select
ctrl_out  output  CTRL_W  raw control of head entry
read_data  output  DATA_W  head entry load data
mem_alu_result  output  DATA_W  head entry ALU result
mem_write_reg  output  REG_AW  head entry destination
wb_data  output  DATA_W  memtoreg ? read_data : mem_alu_result (combinational from head)
occupancy  output  2  entries held: 0, 1 or 2

Behaviour:
- Reset (asynchronous, while reset=1): both entry valid bits 0; all stored fields 0; occupancy=0; out_valid=0; regwrite=0; memtoreg=0; in_ready=1 once reset deasserts.
- Storage: head register (drives outputs) and skid register. in_ready = ~skid_valid (registered, no combinational path from out_ready).
- Accept: in_valid & in_ready. Release: out_valid & out_ready.
- Per edge, without flush:
  - Head empty, accept: the entry loads into the head.
  - Head full, release and no accept: the skid entry (if any) moves to the head, otherwise the head empties.
  - Head full, release and accept: if the skid is empty, the new entry loads into the head; if the skid is full, the skid moves to the head (cannot happen, since in_ready=0).
  - Head full, no release, accept: the entry loads into the skid.
- Ordering strictly FIFO. Throughput 1 entry/cycle with out_ready=1. Latency 1 cycle from accept to out_valid.
- flush=1 at an edge: both valid bits cleared, any simultaneous accept discarded, occupancy=0. Flush overrides release and accept. Data fields may keep stale values.
- regwrite = out_valid & ctrl_out[1] & (mem_write_reg != 0). Writes to x0 are never issued.
- memtoreg = ctrl_out[0], not qualified by valid.
- occupancy = head_valid + skid_valid.
- Reset asserted mid-transfer: the entry is lost; no partial write escapes, because regwrite goes 0 immediately.
- Inputs are sampled only on accept. Changes on the input bus while in_ready=0 have no effect.

Optional Feature:
Macro MEM_WB_FWD_EN.
- Defined: adds inputs fwd_rs1, fwd_rs2 (REG_AW each) and outputs fwd_hit_rs1, fwd_hit_rs2 (1 each).
  - fwd_hit_rsN = regwrite & (mem_write_reg == fwd_rsN), combinational from the head.
  - wb_data is the forwarding value.
- Undefined: those ports and the compare logic are absent; all other behaviour is identical.

Test Plan:
1. Reset with reset=1 mid-cycle -> all outputs 0 asynchronously; after release in_ready=1, occupancy=0.
2. Stream of 4 entries with out_ready=1, ctrl=2'b10, write_reg=5, alu_result=0x10+i -> out_valid one cycle after each accept, mem_alu_result 0x10..0x13 in order, regwrite=1, occupancy=1.
3. out_ready=0 while 3 entries are offered -> first two accepted, occupancy=2, in_ready=0, third held off. Raise out_ready -> entries drain in order, third then accepted.
4. ctrl=2'b11, read_data=0xDEADBEEF, alu=0x1234 -> wb_data=0xDEADBEEF, memtoreg=1. Repeat with ctrl=2'b10 -> wb_data=0x1234.
5. write_reg=0 with ctrl=2'b10 -> out_valid=1, regwrite=0.
6. occupancy=2, then flush=1 together with in_valid=1 -> next cycle occupancy=0, out_valid=0, new entry discarded. With MEM_WB_FWD_EN, fwd_rs1=7 against head write_reg=7, regwrite=1 -> fwd_hit_rs1=1, fwd_hit_rs2=0 for fwd_rs2=8.
